// File: rtl/wb_gpio_pkg.sv
// wb_gpio_pkg: register offsets and shared helpers for the Wishbone GPIO controller.
package wb_gpio_pkg;
    localparam int GPIO_MAX_WIDTH = 32;
    localparam logic [2:0] GPIO_REG_IN      = 3'd0;
    localparam logic [2:0] GPIO_REG_OUT     = 3'd1;
    localparam logic [2:0] GPIO_REG_DIR     = 3'd2;
    localparam logic [2:0] GPIO_REG_RISE_EN = 3'd3;
    localparam logic [2:0] GPIO_REG_FALL_EN = 3'd4;
    localparam logic [2:0] GPIO_REG_STATUS  = 3'd5;
    localparam logic [2:0] GPIO_REG_OUT_SET = 3'd6;
    localparam logic [2:0] GPIO_REG_OUT_CLR = 3'd7;

    function automatic logic [GPIO_MAX_WIDTH-1:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction
endpackage

// File: rtl/wb_gpio_irq_if.sv
// wb_gpio_irq_if: Wishbone classic slave bus bundle for the GPIO controller.
interface wb_gpio_irq_if;
    logic [4:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    modport master(output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
                   input wb_dat_o, wb_ack_o);
    modport slave(input wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
                  output wb_dat_o, wb_ack_o);
endinterface

// File: rtl/gpio_sync.sv
// gpio_sync: multi-stage synchroniser bringing asynchronous pad inputs into the clock domain.
module gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] ff [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) ff[i] <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
        end
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: Wishbone GPIO with per-pin direction and edge interrupts.
// Define GPIO_SETCLR_EN to enable the write-only OUT_SET/OUT_CLR registers.
module wb_gpio_irq
    import wb_gpio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             wb_clk,
    input  logic             wb_rst_n,
    wb_gpio_irq_if.slave     wb,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_dir_o,
    output logic             irq_o
);
    logic [WIDTH-1:0] sync, prev, hit, rise_en, fall_en, status;
    logic [WIDTH-1:0] wm, wd, out_nx, status_nx, rd;
    logic [2:0]       reg_sel;
    logic             req, wr, unused;

    gpio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
        .clk(wb_clk), .rst_n(wb_rst_n), .d(gpio_i), .q(sync)
    );

    assign unused  = ^wb.wb_adr_i[1:0];
    assign req     = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
    assign wr      = req & wb.wb_we_i;
    assign reg_sel = wb.wb_adr_i[4:2];
    assign wm      = WIDTH'(byte_mask(wb.wb_sel_i));
    assign wd      = WIDTH'(wb.wb_dat_i) & wm;

`ifdef GPIO_SETCLR_EN
    assign out_nx = !wr                          ? gpio_o :
                    reg_sel == GPIO_REG_OUT     ? (gpio_o & ~wm) | wd :
                    reg_sel == GPIO_REG_OUT_SET ? gpio_o | wd :
                    reg_sel == GPIO_REG_OUT_CLR ? gpio_o & ~wd : gpio_o;
`else
    assign out_nx = (wr && reg_sel == GPIO_REG_OUT) ? (gpio_o & ~wm) | wd : gpio_o;
`endif

    // Newly detected edges are OR-ed in after the W1C so a coincident set wins.
    assign status_nx = (status & ~((wr && reg_sel == GPIO_REG_STATUS) ? wd : '0)) | hit;

    assign rd = reg_sel == GPIO_REG_IN      ? sync :
                reg_sel == GPIO_REG_OUT     ? gpio_o :
                reg_sel == GPIO_REG_DIR     ? gpio_dir_o :
                reg_sel == GPIO_REG_RISE_EN ? rise_en :
                reg_sel == GPIO_REG_FALL_EN ? fall_en :
                reg_sel == GPIO_REG_STATUS  ? status : '0;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wb.wb_ack_o <= 1'b0;
            wb.wb_dat_o <= '0;
            gpio_o      <= OUT_RESET;
            gpio_dir_o  <= DIR_RESET;
            rise_en     <= '0;
            fall_en     <= '0;
            status      <= '0;
            prev        <= '0;
            hit         <= '0;
            irq_o       <= 1'b0;
        end else begin
            wb.wb_ack_o <= req;
            wb.wb_dat_o <= req ? GPIO_MAX_WIDTH'(rd) : '0;
            gpio_o      <= out_nx;
            if (wr && reg_sel == GPIO_REG_DIR)     gpio_dir_o <= (gpio_dir_o & ~wm) | wd;
            if (wr && reg_sel == GPIO_REG_RISE_EN) rise_en    <= (rise_en & ~wm) | wd;
            if (wr && reg_sel == GPIO_REG_FALL_EN) fall_en    <= (fall_en & ~wm) | wd;
            prev   <= sync;
            // Edges are staged one cycle so STATUS lands SYNC_STAGES+1 edges after the pad sample.
            hit    <= (sync & ~prev & rise_en) | (~sync & prev & fall_en);
            status <= status_nx;
            irq_o  <= |status_nx;
        end
    end
endmodule

// File: tb/tb_wb_gpio_irq.sv
// tb_wb_gpio_irq: table-driven, hand-sequenced and randomized checks of wb_gpio_irq.
module tb_wb_gpio_irq;
`ifdef GPIO_SETCLR_EN
    localparam bit SETCLR = 1'b1;
`else
    localparam bit SETCLR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] gpio_i = 8'h00;
    logic [7:0] gpio_o, gpio_dir;
    logic       irq;
    logic       irq_at_ack;
    int         vectors = 0;
    int         miscompares = 0;

    wb_gpio_irq_if bus();

    wb_gpio_irq #(.WIDTH(8), .OUT_RESET(8'hA5), .DIR_RESET(8'h0F), .SYNC_STAGES(2)) dut (
        .wb_clk(clk), .wb_rst_n(rst_n), .wb(bus),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_dir_o(gpio_dir), .irq_o(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
        logic [7:0]  exp_dir;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [4:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, output logic [31:0] rd);
        @(negedge clk);
        chk("ack_idle", {31'd0, bus.wb_ack_o}, 32'd0);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
        bus.wb_adr_i = adr; bus.wb_sel_i = sel; bus.wb_dat_i = dat;
        @(posedge clk); #1;
        chk("ack_rise", {31'd0, bus.wb_ack_o}, 32'd1);
        rd = bus.wb_dat_o;
        irq_at_ack = irq;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        @(posedge clk); #1;
        chk("ack_single", {31'd0, bus.wb_ack_o}, 32'd0);
        chk("dat_idle", bus.wb_dat_o, 32'd0);
    endtask

    task automatic wr(input logic [4:0] adr, input logic [31:0] dat);
        logic [31:0] rd;
        xfer(1'b1, adr, 4'hF, dat, rd);
    endtask

    task automatic rdchk(input string name, input logic [4:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        xfer(1'b0, adr, 4'hF, 32'd0, rd);
        chk(name, rd, exp);
    endtask

    initial begin
        vec_t        tbl[13];
        logic [31:0] rd;
        logic [7:0]  m[1:4];
        logic [7:0]  mstat, a, b;
        logic [7:0]  hist[$];

        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = '0; bus.wb_sel_i = '0; bus.wb_dat_i = '0;
        tbl[0]  = '{1'b0, 5'h08, 4'hF, 32'h0,         32'h0000000F, 8'hA5, 8'h0F};
        tbl[1]  = '{1'b0, 5'h04, 4'hF, 32'h0,         32'h000000A5, 8'hA5, 8'h0F};
        tbl[2]  = '{1'b1, 5'h04, 4'h1, 32'h12345678,  32'h0,        8'h78, 8'h0F};
        tbl[3]  = '{1'b0, 5'h04, 4'hF, 32'h0,         32'h00000078, 8'h78, 8'h0F};
        tbl[4]  = '{1'b1, 5'h04, 4'hE, 32'hFFFFFF00,  32'h0,        8'h78, 8'h0F};
        tbl[5]  = '{1'b1, 5'h0B, 4'hF, 32'hFFFFFF3C,  32'h0,        8'h78, 8'h3C};
        tbl[6]  = '{1'b0, 5'h08, 4'hF, 32'h0,         32'h0000003C, 8'h78, 8'h3C};
        tbl[7]  = '{1'b1, 5'h00, 4'hF, 32'h000000FF,  32'h0,        8'h78, 8'h3C};
        tbl[8]  = '{1'b0, 5'h00, 4'hF, 32'h0,         32'h00000000, 8'h78, 8'h3C};
        tbl[9]  = '{1'b0, 5'h18, 4'hF, 32'h0,         32'h00000000, 8'h78, 8'h3C};
        tbl[10] = '{1'b0, 5'h1C, 4'hF, 32'h0,         32'h00000000, 8'h78, 8'h3C};
        tbl[11] = '{1'b0, 5'h14, 4'hF, 32'h0,         32'h00000000, 8'h78, 8'h3C};
        tbl[12] = '{1'b1, 5'h08, 4'h1, 32'hFFFFFF00,  32'h0,        8'h78, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", {24'd0, gpio_o}, 32'hA5);
        chk("rst_dir", {24'd0, gpio_dir}, 32'h0F);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
        chk("rst_dat", bus.wb_dat_o, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        foreach (tbl[i]) begin
            xfer(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, rd);
            if (!tbl[i].we) chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_out", i), {24'd0, gpio_o}, {24'd0, tbl[i].exp_out});
            chk($sformatf("tbl%0d_dir", i), {24'd0, gpio_dir}, {24'd0, tbl[i].exp_dir});
        end

        wr(5'h04, 32'h0F);
        wr(5'h18, 32'hF0);
        chk("set_out", {24'd0, gpio_o}, SETCLR ? 32'hFF : 32'h0F);
        rdchk("set_rd", 5'h18, 32'd0);
        wr(5'h1C, 32'h3C);
        chk("clr_out", {24'd0, gpio_o}, SETCLR ? 32'hC3 : 32'h0F);
        rdchk("clr_rd", 5'h1C, 32'd0);
        rdchk("setclr_out_rd", 5'h04, SETCLR ? 32'hC3 : 32'h0F);

        wr(5'h0C, 32'h01);
        @(negedge clk) gpio_i[0] = 1'b1;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1 chk("irq_k2", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1 chk("irq_k3", {31'd0, irq}, 32'd1);
        rdchk("status_rise", 5'h14, 32'h01);
        wr(5'h14, 32'h01);
        chk("irq_w1c", {31'd0, irq_at_ack}, 32'd0);
        rdchk("status_cleared", 5'h14, 32'h00);
        wr(5'h0C, 32'h00);

        @(negedge clk) gpio_i[7] = 1'b1;
        repeat (5) @(posedge clk);
        wr(5'h10, 32'h80);
        @(negedge clk) gpio_i[7] = 1'b0;
        repeat (3) @(posedge clk);
        wr(5'h14, 32'h80);
        chk("irq_set_wins", {31'd0, irq_at_ack}, 32'd1);
        rdchk("status_set_wins", 5'h14, 32'h80);
        wr(5'h14, 32'h80);
        rdchk("status_w1c7", 5'h14, 32'h00);

        for (int r = 1; r <= 4; r++) begin
            m[r] = 8'($urandom);
            wr({3'(r), 2'b00}, {24'd0, m[r]});
        end
        for (int i = 0; i < 40; i++) begin
            int unsigned r = $urandom_range(1, 4);
            logic [31:0] d = $urandom;
            logic [3:0]  s = 4'($urandom);
            xfer(1'b1, {3'(r), 2'($urandom)}, s, d, rd);
            if (s[0]) m[r] = d[7:0];
            rdchk($sformatf("rand_reg%0d", r), {3'(r), 2'b00}, {24'd0, m[r]});
            chk("rand_out", {24'd0, gpio_o}, {24'd0, m[1]});
            chk("rand_dir", {24'd0, gpio_dir}, {24'd0, m[2]});
        end

        wr(5'h14, 32'hFF);
        rdchk("status_pre_rand", 5'h14, 32'h00);
        mstat = 8'h00;
        repeat (4) hist.push_back(gpio_i);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c < 290) gpio_i = 8'($urandom);
            @(posedge clk);
            hist.push_back(gpio_i);
            a = hist[$-3];
            b = hist[$-4];
            mstat |= (a & ~b & m[3]) | (~a & b & m[4]);
            #1 chk("rand_irq", {31'd0, irq}, {31'd0, |mstat});
        end
        rdchk("rand_status", 5'h14, {24'd0, mstat});
        rdchk("rand_in", 5'h00, {24'd0, gpio_i});

        wr(5'h0C, 32'hFF);
        wr(5'h10, 32'hFF);
        @(negedge clk) gpio_i = ~gpio_i;
        repeat (5) @(posedge clk);
        #1 chk("pre_rst_irq", {31'd0, irq}, 32'd1);
        wr(5'h04, 32'h5A);
        wr(5'h08, 32'hF0);
        @(negedge clk);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
        bus.wb_adr_i = 5'h04; bus.wb_sel_i = 4'hF; bus.wb_dat_i = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", {24'd0, gpio_o}, 32'hA5);
        chk("arst_dir", {24'd0, gpio_dir}, 32'h0F);
        chk("arst_irq", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1 chk("arst_noack", {31'd0, bus.wb_ack_o}, 32'd0);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("arst_aborted", {24'd0, gpio_o}, 32'hA5);
        chk("arst_ack_after", {31'd0, bus.wb_ack_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
